tb_mem_ctrl: RTL
================

Name: tb_mem_ctrl

Overview:
- Survivor-memory controller and scheduler for the traceback unit (tbu) of the 8-state Viterbi decoder.
- Stores the 8-bit ACS decision vectors in four rotating banks.
- Each block period it sequences one write bank, one training bank and one decode bank, and drives the tbu enable, selection and data inputs.
- Re-orders the time-reversed decoded bits from the tbu into forward order.

Parameters:
- DEPTH, 16: traceback length; words per bank; must be a power of 2, ≥4.
- WIDTH, 8: decision vector width (one bit per trellis state).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  ACS decision vector valid this cycle.
- din  in  WIDTH  ACS decision vector.
- tbu_enable  out  1  tbu advance enable.
- tbu_selection  out  1  1 = decode phase, 0 = training phase.
- tbu_d_in_0  out  WIDTH  training-bank read data.
- tbu_d_in_1  out  WIDTH  decode-bank read data.
- tbu_d_o  in  1  decoded bit from the tbu.
- tbu_wr_en  in  1  tbu decoded bit valid.
- dec_bit  out  1  decoded bit, forward time order.
- dec_valid  out  1  dec_bit valid.

Behaviour:
- State:
  - phase: 2 bits, bank rotation index.
  - cnt: log2(DEPTH) bits.
  - primed: 2-bit saturating count of completed phases, stops at 3.
- Advance rule: cnt, phase and primed advance only in cycles with din_valid=1. With din_valid=0, nothing advances and no bank is written.
- Write: bank W=phase, address cnt, data din, enable din_valid. cnt increments modulo DEPTH.
- Wrap: when cnt=DEPTH-1 and din_valid=1, cnt wraps to 0, phase increments mod 4 and primed increments (saturating).
- Read addressing:
  - Training bank T=(phase-1) mod 4 and decode bank D=(phase-2) mod 4.
  - Both are read at address DEPTH-1-cnt, i.e. descending, the traceback direction.
  - Bank (phase-3) mod 4 is idle.
- Read timing: banks are synchronous-read, latency 1.
  - tbu_d_in_0 and tbu_d_in_1 are valid the cycle after the address is issued.
  - tbu_enable and tbu_selection are registered one cycle so they align with the read data.
- tbu control:
  - tbu_enable = registered (din_valid && primed≥2).
  - tbu_selection = registered (din_valid && primed==3).
- Output re-ordering:
  - Two DEPTH-bit buffers run ping-pong.
  - Fill: on each tbu_wr_en=1, tbu_d_o is written at fill index wi, and wi increments. When wi wraps from DEPTH-1, the fill buffer swaps and the just-filled buffer is flagged full.
  - Drain: a full buffer drains one bit per cycle from index DEPTH-1 down to 0, asserting dec_valid with dec_bit. The full flag clears after index 0.
  - Because draining takes DEPTH cycles and filling needs at least DEPTH cycles, overflow cannot occur.
- Simultaneous events:
  - A fill-wrap in the same cycle a drain finishes is legal: the new full flag wins.
  - A phase wrap on the same cycle as a write: the write goes to the old bank W, and the new mapping applies from the next cycle.
- Reset: phase=0, cnt=0, primed=0, wi=0, both full flags 0, tbu_enable=0, tbu_selection=0, tbu_d_in_0=0, tbu_d_in_1=0, dec_bit=0, dec_valid=0.
  - Bank contents are not reset.
  - Reset mid-operation discards all buffered bits. After reset, tbu_selection stays 0 until 3 full phases have been written again.
- Latency, din to first dec_valid: 3·DEPTH valid inputs, plus 2 cycles of tbu/controller registers, plus DEPTH fill.

Decomposition:
- Package viterbi_pkg holds:
  - N_STATES=8, WIDTH=8, TB_DEPTH=16.
  - typedef dec_vec_t (logic [WIDTH-1:0]).
  - typedef bank_idx_t (logic [1:0]).
- Sub-module tb_bank: single-port-write, single-port-read, sync-read DEPTH×WIDTH RAM. Instantiate four times.
- Bank-index muxing and the re-order buffers stay in tb_mem_ctrl.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, din_valid=0 → all outputs 0; phase=0, cnt=0 hold indefinitely.
- Bank rotation, DEPTH=16: 64 consecutive valid din=8'hA5 → phase advances at inputs 16, 32, 48.
  - tbu_enable first 1 two cycles after input 32.
  - tbu_selection first 1 two cycles after input 48.
- Read order: write din=cnt+16·phase for 48 inputs → at input 48+k, tbu_d_in_0 shows 47-k and tbu_d_in_1 shows 31-k, one cycle later.
- Stall: drop din_valid for 5 cycles mid-phase → cnt, phase and addresses frozen; tbu_enable=0 during the gap; no bank written.
- Re-order: drive tbu_wr_en=1 with tbu_d_o pattern 1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,1 (16 bits) → 16 cycles of dec_valid with dec_bit 1,0,…,0,1,1, i.e. reversed.
- Reset mid-operation after 40 inputs → all outputs 0 next cycle; tbu_selection 0 until 48 further valid inputs; no stale dec_valid.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi decoder traceback path.
package viterbi_pkg;

    localparam int unsigned N_STATES = 8;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned TB_DEPTH = 16;

    typedef logic [WIDTH-1:0] dec_vec_t;
    typedef logic [1:0]       bank_idx_t;

endpackage

// File: rtl/tb_mem_ctrl_if.sv
// Bus between the ACS/tbu datapath (master) and the survivor-memory controller (slave).
interface tb_mem_ctrl_if #(
    parameter int unsigned WIDTH = viterbi_pkg::WIDTH
);

    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             tbu_enable;
    logic             tbu_selection;
    logic [WIDTH-1:0] tbu_d_in_0;
    logic [WIDTH-1:0] tbu_d_in_1;
    logic             tbu_d_o;
    logic             tbu_wr_en;
    logic             dec_bit;
    logic             dec_valid;

    modport master (
        output din_valid, din, tbu_d_o, tbu_wr_en,
        input  tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1, dec_bit, dec_valid
    );

    modport slave (
        input  din_valid, din, tbu_d_o, tbu_wr_en,
        output tbu_enable, tbu_selection, tbu_d_in_0, tbu_d_in_1, dec_bit, dec_valid
    );

endinterface

// File: rtl/tb_bank.sv
// One survivor-memory bank: single write port, single synchronous read port.
module tb_bank #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tb_mem_ctrl.sv
// Survivor-memory controller: four rotating decision banks feeding the tbu,
// plus ping-pong buffers that restore forward order of the decoded bits.
module tb_mem_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH = TB_DEPTH,
    parameter int unsigned WIDTH = viterbi_pkg::WIDTH
) (
    input logic          clk,
    input logic          rst,
    tb_mem_ctrl_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Bank sequencing state
    bank_idx_t     phase_q, phase_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    primed_q, primed_d;
    bank_idx_t     t_sel_q, d_sel_q;
    logic          tbu_enable_q, tbu_sel_q;

    bank_idx_t     t_bank, d_bank;
    logic [AW-1:0] rd_addr;
    logic [WIDTH-1:0] rdata [4];

    // Re-order state
    logic [1:0][DEPTH-1:0] buf_q, buf_d;
    logic [AW-1:0]         wi_q, wi_d;
    logic [AW-1:0]         ri_q, ri_d;
    logic                  fill_sel_q, fill_sel_d;
    logic                  drain_sel_q, drain_sel_d;
    logic [1:0]            full_q, full_d;
    logic                  dec_bit_q, dec_bit_d;
    logic                  dec_valid_q, dec_valid_d;

    assign t_bank  = phase_q - 2'd1;
    assign d_bank  = phase_q - 2'd2;
    assign rd_addr = AW'(DEPTH - 1) - cnt_q;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        tb_bank #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (bus.din_valid && (phase_q == bank_idx_t'(b))),
            .waddr_i (cnt_q),
            .wdata_i (bus.din),
            .re_i    (bus.din_valid),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        primed_d = primed_q;
        if (bus.din_valid) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == '1) begin
                phase_d = phase_q + 2'd1;
                if (primed_q != 2'd3) begin
                    primed_d = primed_q + 2'd1;
                end
            end
        end
    end

    // Bank selects are captured with the read so the output mux matches the
    // data even if the phase wraps on the issuing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            cnt_q        <= '0;
            primed_q     <= '0;
            t_sel_q      <= '0;
            d_sel_q      <= '0;
            tbu_enable_q <= 1'b0;
            tbu_sel_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
            tbu_enable_q <= bus.din_valid && (primed_q >= 2'd2);
            tbu_sel_q    <= bus.din_valid && (primed_q == 2'd3);
            if (bus.din_valid) begin
                t_sel_q <= t_bank;
                d_sel_q <= d_bank;
            end
        end
    end

    always_comb begin
        buf_d       = buf_q;
        wi_d        = wi_q;
        ri_d        = ri_q;
        fill_sel_d  = fill_sel_q;
        drain_sel_d = drain_sel_q;
        full_d      = full_q;
        dec_bit_d   = dec_bit_q;
        dec_valid_d = 1'b0;
        if (full_q[drain_sel_q]) begin
            dec_valid_d = 1'b1;
            dec_bit_d   = buf_q[drain_sel_q][ri_q];
            ri_d        = ri_q - AW'(1);
            if (ri_q == '0) begin
                full_d[drain_sel_q] = 1'b0;
                drain_sel_d         = ~drain_sel_q;
            end
        end
        // Applied after the drain so a fill completing this cycle keeps its flag.
        if (bus.tbu_wr_en) begin
            buf_d[fill_sel_q][wi_q] = bus.tbu_d_o;
            wi_d                    = wi_q + AW'(1);
            if (wi_q == '1) begin
                full_d[fill_sel_q] = 1'b1;
                fill_sel_d         = ~fill_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q       <= '0;
            wi_q        <= '0;
            ri_q        <= '1;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            full_q      <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            wi_q        <= wi_d;
            ri_q        <= ri_d;
            fill_sel_q  <= fill_sel_d;
            drain_sel_q <= drain_sel_d;
            full_q      <= full_d;
            dec_bit_q   <= dec_bit_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign bus.tbu_enable    = tbu_enable_q;
    assign bus.tbu_selection = tbu_sel_q;
    assign bus.tbu_d_in_0    = rdata[t_sel_q];
    assign bus.tbu_d_in_1    = rdata[d_sel_q];
    assign bus.dec_bit       = dec_bit_q;
    assign bus.dec_valid     = dec_valid_q;

endmodule
